// File: rtl/control_sequencer.sv
// control_sequencer -- fetch/execute control FSM for a small accumulator CPU.
// Walks a synchronous program ROM and decodes each instruction into
// register-file and ALU controls. It also handles jumps, the operator
// handshake (WAIT) and HALT.
// Optional feature: define CONTROL_SEQUENCER_SYNC_EN to pass hsSwitch through a
// 2-flop synchronizer. This adds 2 cycles of handshake latency. Without the
// macro, the FSM samples hsSwitch directly.

package cpuConfig;
    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_MUL  = 2'b10,
        ALU_PASS = 2'b11
    } aluFunc_t;
endpackage

module control_sequencer #(
    parameter int N      = 8,
    parameter int A_SIZE = 3,
    parameter int R_SIZE = 3
) (
    input  logic                      clk,
    input  logic                      nReset,
    input  logic [3+R_SIZE+N-1:0]     instr,
    input  logic                      hsSwitch,
    output logic [A_SIZE-1:0]         pcAddr,
    output logic                      writeReg,
    output cpuConfig::aluFunc_t       aluFunc,
    output logic                      aluImmediate,
    output logic                      immSwitches,
    output logic [R_SIZE-1:0]         opD,
    output logic [N-1:0]              opT,
    output logic                      waiting,
    output logic                      halted
);

    localparam int I_W = 3 + R_SIZE + N;

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        EXEC    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        HALT    = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADDI = 3'b001,
        OP_SUB  = 3'b010,
        OP_MULI = 3'b011,
        OP_LDSW = 3'b100,
        OP_WAIT = 3'b101,
        OP_JMP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_t;

    state_t             state_q, state_d;
    logic [A_SIZE-1:0]  pc_q, pc_d;
    logic [A_SIZE-1:0]  pc_inc_s;
    opcode_t            opcode_s;
    logic [R_SIZE-1:0]  field_d_s;
    logic [N-1:0]       field_t_s;
    logic               hs_s;

    assign opcode_s  = opcode_t'(instr[I_W-1:I_W-3]);
    assign field_d_s = instr[I_W-4:N];
    assign field_t_s = instr[N-1:0];
    // Natural wrap of the A_SIZE-bit adder gives the modulo-2^A_SIZE increment.
    assign pc_inc_s  = pc_q + {{(A_SIZE-1){1'b0}}, 1'b1};
    assign pcAddr    = pc_q;

`ifdef CONTROL_SEQUENCER_SYNC_EN
    logic sync1_q, sync2_q;

    // Two-flop synchronizer bringing the asynchronous operator switch into clk.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= hsSwitch;
            sync2_q <= sync1_q;
        end
    end

    assign hs_s = sync2_q;
`else
    assign hs_s = hsSwitch;
`endif

    // State and program-counter registers; reset restarts execution at address 0.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= FETCH;
            pc_q    <= {A_SIZE{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, next-PC and instruction decode. Controls are only active in EXEC.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        writeReg     = 1'b0;
        aluFunc      = cpuConfig::ALU_ADD;
        aluImmediate = 1'b0;
        immSwitches  = 1'b0;
        opD          = {R_SIZE{1'b0}};
        opT          = {N{1'b0}};
        waiting      = 1'b0;
        halted       = 1'b0;
        case (state_q)
            FETCH: begin
                // One cycle for the ROM to present the word at pcAddr.
                state_d = EXEC;
            end
            EXEC: begin
                opD = field_d_s;
                opT = field_t_s;
                case (opcode_s)
                    OP_ADD: begin
                        writeReg = 1'b1;
                        pc_d     = pc_inc_s;
                        state_d  = FETCH;
                    end
                    OP_ADDI: begin
                        writeReg     = 1'b1;
                        aluImmediate = 1'b1;
                        pc_d         = pc_inc_s;
                        state_d      = FETCH;
                    end
                    OP_SUB: begin
                        writeReg = 1'b1;
                        aluFunc  = cpuConfig::ALU_SUB;
                        pc_d     = pc_inc_s;
                        state_d  = FETCH;
                    end
                    OP_MULI: begin
                        writeReg     = 1'b1;
                        aluImmediate = 1'b1;
                        aluFunc      = cpuConfig::ALU_MUL;
                        pc_d         = pc_inc_s;
                        state_d      = FETCH;
                    end
                    OP_LDSW: begin
                        writeReg     = 1'b1;
                        aluImmediate = 1'b1;
                        immSwitches  = 1'b1;
                        pc_d         = pc_inc_s;
                        state_d      = FETCH;
                    end
                    OP_WAIT: begin
                        // PC advances only once the handshake completes.
                        state_d = WAIT_HI;
                    end
                    OP_JMP: begin
                        pc_d    = field_t_s[A_SIZE-1:0];
                        state_d = FETCH;
                    end
                    OP_HALT: begin
                        state_d = HALT;
                    end
                    default: begin
                        state_d = FETCH;
                    end
                endcase
            end
            WAIT_HI: begin
                waiting = 1'b1;
                if (hs_s) begin
                    state_d = WAIT_LO;
                end else begin
                    state_d = WAIT_HI;
                end
            end
            WAIT_LO: begin
                waiting = 1'b1;
                if (!hs_s) begin
                    pc_d    = pc_inc_s;
                    state_d = FETCH;
                end else begin
                    state_d = WAIT_LO;
                end
            end
            HALT: begin
                halted  = 1'b1;
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
                pc_d    = {A_SIZE{1'b0}};
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios plus random
// ALU/JMP programs checked against an instruction-level reference model.
module tb_control_sequencer;

    localparam int N      = 8;
    localparam int A_SIZE = 3;
    localparam int R_SIZE = 3;
    localparam int I_W    = 3 + R_SIZE + N;
`ifdef CONTROL_SEQUENCER_SYNC_EN
    localparam int HS_LAT = 3;
`else
    localparam int HS_LAT = 1;
`endif

    logic                clk = 1'b0;
    logic                nReset = 1'b0;
    logic [I_W-1:0]      instr = '0;
    logic                hsSwitch = 1'b0;
    logic [A_SIZE-1:0]   pcAddr;
    logic                writeReg;
    cpuConfig::aluFunc_t aluFunc;
    logic                aluImmediate;
    logic                immSwitches;
    logic [R_SIZE-1:0]   opD;
    logic [N-1:0]        opT;
    logic                waiting;
    logic                halted;

    logic [I_W-1:0] rom [0:7];
    int checks = 0;
    int errors = 0;

    control_sequencer #(.N(N), .A_SIZE(A_SIZE), .R_SIZE(R_SIZE)) dut (
        .clk(clk), .nReset(nReset), .instr(instr), .hsSwitch(hsSwitch),
        .pcAddr(pcAddr), .writeReg(writeReg), .aluFunc(aluFunc),
        .aluImmediate(aluImmediate), .immSwitches(immSwitches),
        .opD(opD), .opT(opT), .waiting(waiting), .halted(halted)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data valid one cycle after the address.
    always @(posedge clk) instr <= rom[pcAddr];

    function automatic logic [I_W-1:0] enc(input int op, input int d, input int t);
        logic [2:0] o = 3'(op);
        logic [R_SIZE-1:0] dd = R_SIZE'(d);
        logic [N-1:0] tt = N'(t);
        return {o, dd, tt};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Hold reset for two cycles, then release mid-cycle ("cycle 1" sample point).
    task automatic do_reset();
        @(negedge clk);
        nReset = 1'b0;
        hsSwitch = 1'b0;
        #1;
        chk("rst_pc", 32'(pcAddr), 32'd0);
        chk("rst_we", 32'(writeReg), 32'd0);
        chk("rst_wait", 32'(waiting), 32'd0);
        chk("rst_halt", 32'(halted), 32'd0);
        next_cycle();
        next_cycle();
        nReset = 1'b1;
    endtask

    // Controls expected in EXEC from the opcode table.
    task automatic exp_ctrl(input int op, output logic we, output logic imm,
                            output logic sw, output int func);
        we = 1'b0; imm = 1'b0; sw = 1'b0; func = -1;
        case (op)
            0: begin we = 1'b1; func = int'(cpuConfig::ALU_ADD); end
            1: begin we = 1'b1; imm = 1'b1; func = int'(cpuConfig::ALU_ADD); end
            2: begin we = 1'b1; func = int'(cpuConfig::ALU_SUB); end
            3: begin we = 1'b1; imm = 1'b1; func = int'(cpuConfig::ALU_MUL); end
            4: begin we = 1'b1; imm = 1'b1; sw = 1'b1; func = int'(cpuConfig::ALU_ADD); end
            default: begin end
        endcase
    endtask

    // Instruction-level model: each instruction is a FETCH cycle then an EXEC cycle.
    task automatic run_model(input int n_instr);
        int mpc = 0;
        logic we, imm, sw;
        int func, op, d, t;
        do_reset();
        for (int i = 0; i < n_instr; i++) begin
            chk("f_pc", 32'(pcAddr), 32'(mpc));
            chk("f_we", 32'(writeReg), 32'd0);
            chk("f_imm", 32'(aluImmediate), 32'd0);
            chk("f_func", 32'(aluFunc), 32'(cpuConfig::ALU_ADD));
            next_cycle();
            op = int'(rom[mpc][I_W-1:I_W-3]);
            d  = int'(rom[mpc][I_W-4:N]);
            t  = int'(rom[mpc][N-1:0]);
            exp_ctrl(op, we, imm, sw, func);
            chk("e_pc", 32'(pcAddr), 32'(mpc));
            chk("e_we", 32'(writeReg), 32'(we));
            chk("e_imm", 32'(aluImmediate), 32'(imm));
            chk("e_sw", 32'(immSwitches), 32'(sw));
            chk("e_opD", 32'(opD), 32'(d));
            chk("e_opT", 32'(opT), 32'(t));
            if (func >= 0) chk("e_func", 32'(aluFunc), 32'(func));
            next_cycle();
            mpc = (op == 6) ? (t % 8) : ((mpc + 1) % 8);
        end
    endtask

    initial begin
        int op_r, cnt;
        logic exp_we;
        int exp_pc;

        // Three-instruction program ending in HALT.
        rom[0] = enc(1, 1, 5); rom[1] = enc(1, 1, 3); rom[2] = enc(7, 0, 0);
        for (int a = 3; a < 8; a++) rom[a] = enc(0, 0, 0);
        do_reset();
        for (int cyc = 1; cyc <= 12; cyc++) begin
            exp_we = (cyc == 2 || cyc == 4);
            exp_pc = (cyc <= 2) ? 0 : (cyc <= 4) ? 1 : 2;
            chk("halt_we", 32'(writeReg), 32'(exp_we));
            chk("halt_pc", 32'(pcAddr), 32'(exp_pc));
            if (cyc == 2) chk("halt_opT1", 32'(opT), 32'd5);
            if (cyc == 4) chk("halt_opT2", 32'(opT), 32'd3);
            if (exp_we) chk("halt_opD", 32'(opD), 32'd1);
            if (cyc < 6) chk("halt_early", 32'(halted), 32'd0);
            if (cyc >= 7) chk("halted", 32'(halted), 32'd1);
            next_cycle();
        end

        // Seven ADDs then JMP 0 at address 7.
        for (int a = 0; a < 7; a++) rom[a] = enc(0, a, a + 16);
        rom[7] = enc(6, 0, 0);
        run_model(10);

        // LDSW r2.
        rom[0] = enc(4, 2, 8'hA5);
        do_reset();
        next_cycle();
        chk("ldsw_imm", 32'(aluImmediate), 32'd1);
        chk("ldsw_sw", 32'(immSwitches), 32'd1);
        chk("ldsw_we", 32'(writeReg), 32'd1);
        chk("ldsw_opD", 32'(opD), 32'd2);

        // WAIT handshake then ADDI r3.
        rom[0] = enc(5, 0, 0); rom[1] = enc(1, 3, 9);
        do_reset();
        next_cycle();
        chk("wait_exec", 32'(waiting), 32'd0);
        next_cycle();
        for (int i = 0; i < 20; i++) begin
            chk("wait_hi", 32'(waiting), 32'd1);
            chk("wait_pc", 32'(pcAddr), 32'd0);
            next_cycle();
        end
        hsSwitch = 1'b1;
        for (int i = 0; i < HS_LAT + 2; i++) begin
            chk("wait_lo", 32'(waiting), 32'd1);
            next_cycle();
        end
        hsSwitch = 1'b0;
        cnt = 0;
        while (waiting && cnt < 10) begin
            next_cycle();
            cnt++;
        end
        chk("wait_exit_lat", 32'(cnt), 32'(HS_LAT));
        chk("wait_exit_pc", 32'(pcAddr), 32'd1);
        next_cycle();
        chk("wait_next_we", 32'(writeReg), 32'd1);
        chk("wait_next_opD", 32'(opD), 32'd3);

        // Reset during EXEC of ADD.
        rom[0] = enc(0, 4, 1); rom[1] = enc(5, 0, 0);
        do_reset();
        next_cycle();
        chk("mid_we_pre", 32'(writeReg), 32'd1);
        nReset = 1'b0;
        #1;
        chk("mid_we_drop", 32'(writeReg), 32'd0);
        chk("mid_pc", 32'(pcAddr), 32'd0);
        next_cycle();
        nReset = 1'b1;
        next_cycle();
        chk("mid_restart_pc", 32'(pcAddr), 32'd0);
        chk("mid_restart_we", 32'(writeReg), 32'd1);
        // Reset during WAIT_HI at address 1.
        next_cycle();
        next_cycle();
        next_cycle();
        chk("whi_wait", 32'(waiting), 32'd1);
        chk("whi_pc", 32'(pcAddr), 32'd1);
        nReset = 1'b0;
        #1;
        chk("whi_wait_drop", 32'(waiting), 32'd0);
        chk("whi_pc_drop", 32'(pcAddr), 32'd0);
        next_cycle();
        nReset = 1'b1;
        next_cycle();
        chk("whi_restart_pc", 32'(pcAddr), 32'd0);
        chk("whi_restart_opD", 32'(opD), 32'd4);

        // Random ALU/JMP programs.
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 8; a++) begin
                op_r = int'($urandom_range(0, 9));
                if (op_r > 5) op_r = op_r - 6;
                if (op_r == 5) op_r = 6;
                rom[a] = enc(op_r, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
            end
            run_model(24);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
